// File: rtl/leaf_refill_scheduler_pkg.sv
// Shared definitions for the merger-tree leaf refill logic.
// Holds the scheduler FSM state encoding, the line size in words and the default
// per-leaf buffer depth in lines.
package leaf_refill_scheduler_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StInit = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // 512-bit line of 32-bit words
  localparam int unsigned LineWords       = 16;
  localparam int unsigned BufLinesDefault = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: finds the lowest-index request at or after i_ptr, wrapping
// modulo LEAF_CNT.
// Ports:
//   i_req  request vector, one bit per leaf
//   i_ptr  search start index (must be < LEAF_CNT)
//   o_gnt  one-hot grant
//   o_idx  index of the granted leaf
//   o_any  high when any request is set
module rr_arbiter #(
  parameter int unsigned LEAF_CNT = 4,
  localparam int unsigned IdxW = (LEAF_CNT > 1) ? $clog2(LEAF_CNT) : 1
) (
  input  logic [LEAF_CNT-1:0] i_req,
  input  logic [IdxW-1:0]     i_ptr,
  output logic [LEAF_CNT-1:0] o_gnt,
  output logic [IdxW-1:0]     o_idx,
  output logic                o_any
);

  always_comb begin
    int unsigned k;
    logic [IdxW-1:0] kk;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    k     = 0;
    kk    = '0;
    for (int unsigned off = 0; off < LEAF_CNT; off++) begin
      k  = (32'(i_ptr) + off) % LEAF_CNT;
      kk = IdxW'(k);
      if (!o_any && i_req[kk]) begin
        o_any     = 1'b1;
        o_idx     = kk;
        o_gnt[kk] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_refill_scheduler.sv
// Schedules line reads that refill the leaf buffers of a merge tree.
// On i_start each leaf l gets the word range [base+l*len, base+(l+1)*len) and a full
// credit count; leaves with data left and free buffer space are served round-robin,
// with up to BURST_SIZE consecutive grants to one leaf.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 begin a pass (ignored while busy)
//   i_base_addr, i_seq_len  leaf 0 start address and words per leaf, sampled at start
//   i_leaf_deq              per-leaf line-consumed pulses (return one credit)
//   o_rd_valid/addr/leaf    registered line-read request, held until i_rd_ready
//   o_busy, o_done, o_err   INIT/RUN, DONE, sticky credit overflow
module leaf_refill_scheduler
  import leaf_refill_scheduler_pkg::*;
#(
  parameter int unsigned LEAF_CNT   = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WORDS = LineWords,
  parameter int unsigned BUF_LINES  = BufLinesDefault,
  parameter int unsigned BURST_SIZE = 1,
  localparam int unsigned LeafW = (LEAF_CNT > 1) ? $clog2(LEAF_CNT) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_seq_len,
  input  logic [LEAF_CNT-1:0]   i_leaf_deq,
  output logic                  o_rd_valid,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [LeafW-1:0]      o_rd_leaf,
  input  logic                  i_rd_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned CredW  = $clog2(BUF_LINES + 1);
  localparam int unsigned BurstW = $clog2(BURST_SIZE + 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] acc_q, acc_d, len_q, len_d;
  logic [LeafW-1:0]      init_idx_q, init_idx_d;
  logic [ADDR_WIDTH-1:0] rdaddr_q [LEAF_CNT];
  logic [ADDR_WIDTH-1:0] rdaddr_d [LEAF_CNT];
  logic [ADDR_WIDTH-1:0] end_q    [LEAF_CNT];
  logic [ADDR_WIDTH-1:0] end_d    [LEAF_CNT];
  logic [CredW-1:0]      cred_q   [LEAF_CNT];
  logic [CredW-1:0]      cred_d   [LEAF_CNT];
  logic [LeafW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BurstW-1:0]     burst_q, burst_d, burst_next;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LeafW-1:0]      rd_leaf_q, rd_leaf_d;
  logic                  err_q, err_d;

  logic [LEAF_CNT-1:0] pending, elig, gnt;
  logic [LeafW-1:0]    gnt_idx;
  logic                gnt_any, grant, stay;

  always_comb begin
    for (int l = 0; l < LEAF_CNT; l++) begin
      pending[l] = rdaddr_q[l] < end_q[l];
      elig[l]    = pending[l] && (cred_q[l] != '0);
    end
  end

  rr_arbiter #(
    .LEAF_CNT(LEAF_CNT)
  ) u_rr_arbiter (
    .i_req(elig),
    .i_ptr(rr_ptr_q),
    .o_gnt(gnt),
    .o_idx(gnt_idx),
    .o_any(gnt_any)
  );

  assign grant = (state_q == StRun) && (!rd_valid_q || i_rd_ready) && gnt_any;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    len_d      = len_q;
    init_idx_d = init_idx_q;
    rdaddr_d   = rdaddr_q;
    end_d      = end_q;
    cred_d     = cred_q;
    rr_ptr_d   = rr_ptr_q;
    burst_d    = burst_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    rd_leaf_d  = rd_leaf_q;
    err_d      = err_q;
    stay       = 1'b0;
    // Consecutive grant count including this one; restarts when the pointer moved on.
    burst_next = ((gnt_idx == rr_ptr_q) && (burst_q != '0)) ? burst_q + BurstW'(1) : BurstW'(1);

    // Credit accounting; a grant and a deq on the same leaf cancel out.
    if ((state_q == StRun) || (state_q == StDone)) begin
      for (int l = 0; l < LEAF_CNT; l++) begin
        if ((grant && gnt[l]) && !i_leaf_deq[l]) begin
          cred_d[l] = cred_q[l] - CredW'(1);
        end else if (!(grant && gnt[l]) && i_leaf_deq[l]) begin
          if (cred_q[l] == CredW'(BUF_LINES)) err_d = 1'b1;
          else cred_d[l] = cred_q[l] + CredW'(1);
        end
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          state_d    = StInit;
          acc_d      = i_base_addr;
          len_d      = i_seq_len;
          init_idx_d = '0;
          rr_ptr_d   = '0;
          burst_d    = '0;
        end
      end
      StInit: begin
        // One add per cycle walks the accumulator across the leaf ranges.
        rdaddr_d[init_idx_q] = acc_q;
        end_d[init_idx_q]    = acc_q + len_q;
        cred_d[init_idx_q]   = CredW'(BUF_LINES);
        acc_d                = acc_q + len_q;
        init_idx_d           = init_idx_q + LeafW'(1);
        if (init_idx_q == LeafW'(LEAF_CNT - 1)) begin
          state_d = (len_q == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (pending == '0 && !rd_valid_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (grant) begin
      rdaddr_d[gnt_idx] = rdaddr_q[gnt_idx] + ADDR_WIDTH'(LINE_WORDS);
      rd_valid_d        = 1'b1;
      rd_addr_d         = rdaddr_q[gnt_idx];
      rd_leaf_d         = gnt_idx;
      stay = (32'(burst_next) < BURST_SIZE) && (rdaddr_d[gnt_idx] < end_q[gnt_idx]) &&
             (cred_d[gnt_idx] != '0);
      if (stay) begin
        rr_ptr_d = gnt_idx;
        burst_d  = burst_next;
      end else begin
        rr_ptr_d = (gnt_idx == LeafW'(LEAF_CNT - 1)) ? '0 : gnt_idx + LeafW'(1);
        burst_d  = '0;
      end
    end else if (i_rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      len_q      <= '0;
      init_idx_q <= '0;
      rr_ptr_q   <= '0;
      burst_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_leaf_q  <= '0;
      err_q      <= 1'b0;
      for (int l = 0; l < LEAF_CNT; l++) begin
        rdaddr_q[l] <= '0;
        end_q[l]    <= '0;
        cred_q[l]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      len_q      <= len_d;
      init_idx_q <= init_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      burst_q    <= burst_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_leaf_q  <= rd_leaf_d;
      err_q      <= err_d;
      rdaddr_q   <= rdaddr_d;
      end_q      <= end_d;
      cred_q     <= cred_d;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_leaf  = rd_leaf_q;
  assign o_busy     = (state_q == StInit) || (state_q == StRun);
  assign o_done     = (state_q == StDone);
  assign o_err      = err_q;

endmodule
